// File: rtl/fetch_stage_r0.sv
// Purpose  : RISC-V instruction fetch stage and IF/ID register with skid buffer and stall/flush counters.
// Latency  : 1 cycle imem read, 1 cycle fetch-to-IF/ID; a redirect costs exactly one bubble.
// Backpress: IF_ID_Hold=0 freezes IF/ID and parks the in-flight imem word in a skid register; PCWrite=0 holds the PC.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   PCWrite, IF_ID_Hold,       hazard-unit controls (Hold is active-low:
//   IF_ID_Flush                0 = keep IF/ID contents)
//   redirect_valid/_pc         taken branch/jump target from ID
//   imem_addr / imem_rdata     synchronous-read instruction memory port
//   IF_ID_*                    IF/ID contents plus decoded hazard fields
//   stall_cnt, flush_cnt       saturating performance counters
//   protocol_err               sticky PCWrite-while-held indicator
module fetch_stage_r0 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IF_ID_Hold,
    input  logic             IF_ID_Flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             IF_ID_Valid,
    output logic [31:0]      IF_ID_PC,
    output logic [31:0]      IF_ID_PC4,
    output logic [31:0]      IF_ID_Instr,
    output logic [7:0]       IF_ID_Opcode,
    output logic [4:0]       IF_ID_Rs,
    output logic [4:0]       IF_ID_Rt,
    output logic [4:0]       IF_ID_Rd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             protocol_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      f2_pc_q, f2_pc_d;
    logic             f2_valid_q, f2_valid_d;
    logic [31:0]      skid_q, skid_d;
    logic             use_skid_q, use_skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             perr_q, perr_d;

    // Kill covers both an explicit flush and a redirect: the word returning
    // from memory next cycle belongs to the wrong path either way.
    logic kill;
    assign kill = IF_ID_Flush | redirect_valid;

    always_comb begin
        // PC: redirect has priority over PCWrite=0
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (PCWrite) begin
            pc_d = pc_q + 32'd4;
        end

        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        skid_d     = skid_q;
        use_skid_d = use_skid_q;
        if (kill) begin
            f2_valid_d = 1'b0;
            use_skid_d = 1'b0;
        end else if (!IF_ID_Hold) begin
            // imem_rdata only belongs to f2_pc_q in the first held cycle;
            // afterwards memory is reading the next address, so park it once.
            if (!use_skid_q) begin
                skid_d     = imem_rdata;
                use_skid_d = 1'b1;
            end
        end else begin
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
            use_skid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!IF_ID_Hold && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (IF_ID_Flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end

        // Advancing the PC while IF/ID is frozen drops a sequential instruction.
        perr_d = perr_q | (PCWrite & ~IF_ID_Hold & ~kill);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            f2_pc_q     <= 32'h0;
            f2_valid_q  <= 1'b0;
            skid_q      <= 32'h0;
            use_skid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            f2_pc_q     <= f2_pc_d;
            f2_valid_q  <= f2_valid_d;
            skid_q      <= skid_d;
            use_skid_q  <= use_skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            perr_q      <= perr_d;
        end
    end

    // Outputs depend only on registers and imem_rdata.
    assign imem_addr    = pc_q;
    assign IF_ID_Valid  = f2_valid_q;
    assign IF_ID_PC     = f2_pc_q;
    assign IF_ID_PC4    = f2_pc_q + 32'd4;
    // An empty IF/ID shows NOP so ID never decodes a stale branch/jump.
    assign IF_ID_Instr  = !f2_valid_q ? NOP : (use_skid_q ? skid_q : imem_rdata);
    assign IF_ID_Opcode = {IF_ID_Instr[14:12], IF_ID_Instr[6:2]};
    assign IF_ID_Rs     = IF_ID_Instr[19:15];
    assign IF_ID_Rt     = IF_ID_Instr[24:20];
    assign IF_ID_Rd     = IF_ID_Instr[11:7];
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_fetch_stage_r0.sv
// Purpose  : self-checking bench for fetch_stage_r0 with a scoreboard queue and negedge monitor.
// Latency  : expected entries are tagged with the cycle in which they must appear.
// Backpress: none; memory model returns mem[a] = a one cycle after the address.
module tb_fetch_stage_r0;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, IF_ID_Hold, IF_ID_Flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        IF_ID_Valid;
    logic [31:0] IF_ID_PC, IF_ID_PC4, IF_ID_Instr;
    logic [7:0]  IF_ID_Opcode;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic [15:0] stall_cnt, flush_cnt;
    logic        protocol_err;

    fetch_stage_r0 #(
        .RESET_PC(32'h0000_0100),
        .CNT_W   (16),
        .NOP     (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .IF_ID_Hold    (IF_ID_Hold),
        .IF_ID_Flush   (IF_ID_Flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .IF_ID_Valid   (IF_ID_Valid),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_PC4     (IF_ID_PC4),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Opcode  (IF_ID_Opcode),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .IF_ID_Rd      (IF_ID_Rd),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    // synchronous-read memory with mem[a] = a
    always @(posedge clk) imem_rdata <= imem_addr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        perr;
        logic        cc;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] opc(input logic [31:0] i);
        return {i[14:12], i[6:2]};
    endfunction

    // monitor: compare every scoreboard entry due in the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missed_check: expected cycle %0d, now %0d", e.cyc, cyc);
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("valid", {31'b0, IF_ID_Valid}, {31'b0, e.valid});
            chk("instr", IF_ID_Instr, e.instr);
            chk("opcode", {24'b0, IF_ID_Opcode}, {24'b0, opc(e.instr)});
            chk("rs", {27'b0, IF_ID_Rs}, {27'b0, e.instr[19:15]});
            chk("rt", {27'b0, IF_ID_Rt}, {27'b0, e.instr[24:20]});
            chk("rd", {27'b0, IF_ID_Rd}, {27'b0, e.instr[11:7]});
            chk("protocol_err", {31'b0, protocol_err}, {31'b0, e.perr});
            if (e.valid || e.cc) begin
                chk("if_id_pc", IF_ID_PC, e.pc);
                chk("if_id_pc4", IF_ID_PC4, e.pc + 32'd4);
            end
            if (e.cc) begin
                chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, e.stall});
                chk("flush_cnt", {16'b0, flush_cnt}, {16'b0, e.flush});
            end
        end
    end

    task automatic set_in(input logic pcw, input logic hold, input logic fl,
                          input logic rv, input logic [31:0] rpc, input logic r);
        PCWrite        = pcw;
        IF_ID_Hold     = hold;
        IF_ID_Flush    = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rst            = r;
    endtask

    // apply one cycle of inputs; expected state is due right after the edge
    task automatic step(input logic pcw, input logic hold, input logic fl,
                        input logic rv, input logic [31:0] rpc, input logic r,
                        input logic [31:0] ea, input logic ev, input logic [31:0] epc,
                        input logic [31:0] ei, input logic ep,
                        input logic cc, input logic [15:0] es, input logic [15:0] ef);
        exp_t e;
        set_in(pcw, hold, fl, rv, rpc, r);
        e.cyc = cyc + 1; e.addr = ea; e.valid = ev; e.pc = epc; e.instr = ei;
        e.perr = ep; e.cc = cc; e.stall = es; e.flush = ef;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic pcw, input logic hold, input logic fl,
                       input logic rv, input logic [31:0] rpc, input logic r);
        set_in(pcw, hold, fl, rv, rpc, r);
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] N = 32'h0000_0013;

    initial begin
        // --- reset, then sequential fetch from 0x100
        //    pcw hold fl rv rpc  rst   addr   v  pc    instr  perr cc stall flush
        step(1, 1, 0, 0, 0, 1,  32'h100, 0, 32'h0,   N,       0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1,  32'h100, 0, 32'h0,   N,       0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h104, 1, 32'h100, 32'h100, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h108, 1, 32'h104, 32'h104, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h10C, 1, 32'h108, 32'h108, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h110, 1, 32'h10C, 32'h10C, 0, 0, 0, 0);
        // --- load-use stall for 3 cycles at 0x10C
        step(0, 0, 0, 0, 0, 0,  32'h110, 1, 32'h10C, 32'h10C, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0,  32'h110, 1, 32'h10C, 32'h10C, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0,  32'h110, 1, 32'h10C, 32'h10C, 0, 1, 3, 0);
        step(1, 1, 0, 0, 0, 0,  32'h114, 1, 32'h110, 32'h110, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h118, 1, 32'h114, 32'h114, 0, 1, 3, 0);
        // --- reset and redirect to 0x200 while IF/ID = 0x108
        step(1, 1, 0, 0, 0, 1,  32'h100, 0, 32'h0,   N,       0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h104, 1, 32'h100, 32'h100, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h108, 1, 32'h104, 32'h104, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h10C, 1, 32'h108, 32'h108, 0, 0, 0, 0);
        step(1, 1, 1, 1, 32'h200, 0, 32'h200, 0, 32'h108, N,  0, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0,  32'h204, 1, 32'h200, 32'h200, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h208, 1, 32'h204, 32'h204, 0, 0, 0, 0);
        // --- hold loads skid, then flush+hold+redirect: flush wins, skid dropped
        step(0, 0, 0, 0, 0, 0,  32'h208, 1, 32'h204, 32'h204, 0, 1, 1, 1);
        step(0, 0, 1, 1, 32'h300, 0, 32'h300, 0, 32'h204, N,  0, 1, 2, 2);
        step(1, 1, 0, 0, 0, 0,  32'h304, 1, 32'h300, 32'h300, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h308, 1, 32'h304, 32'h304, 0, 0, 0, 0);
        // --- PC wrap from 0xFFFFFFFC
        step(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, N, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h0,   1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 2, 3);
        step(1, 1, 0, 0, 0, 0,  32'h4,   1, 32'h0,   32'h0,   0, 0, 0, 0);
        // --- PCWrite while held: sticky protocol_err, sequential instr lost
        step(1, 0, 0, 0, 0, 0,  32'h8,   1, 32'h0,   32'h0,   1, 1, 3, 3);
        step(1, 1, 0, 0, 0, 0,  32'hC,   1, 32'h8,   32'h8,   1, 0, 0, 0);
        // --- reset in the second cycle of a hold: skid discarded
        step(0, 0, 0, 0, 0, 0,  32'hC,   1, 32'h8,   32'h8,   1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1,  32'h100, 0, 32'h0,   N,       0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0,  32'h104, 1, 32'h100, 32'h100, 0, 0, 0, 0);
        // --- stall counter saturation
        for (int i = 0; i < 65540; i++) drv(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0,  32'h104, 1, 32'h100, 32'h100, 0, 1, 16'hFFFF, 0);

        set_in(1, 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 required", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage_r0.md
# fetch_stage_r0

Instruction fetch stage and IF/ID pipeline register for the 32-bit RISC-V pipeline, sitting directly upstream of the hazard detection unit and the decoder. It owns the PC, issues addresses to a synchronous-read instruction memory, and presents the fetched instruction plus decoded hazard fields to ID. It obeys the hazard unit's PCWrite, IF_ID_Hold (active-low hold) and IF_ID_Flush controls, and keeps saturating stall and flush counters.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CNT_W, 16, width of performance counters
- NOP, 32'h0000_0013, instruction presented when IF/ID is empty (addi x0,x0,0)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- PCWrite  in  1  1 = PC may advance sequentially; 0 = PC holds
- IF_ID_Hold  in  1  1 = IF/ID loads normally; 0 = IF/ID keeps current contents
- IF_ID_Flush  in  1  1 = kill the in-flight fetch (IF/ID empty next cycle)
- redirect_valid  in  1  taken branch/jump resolved in ID
- redirect_pc  in  32  target address, word aligned
- imem_addr  out  32  fetch address (= pc_q)
- imem_rdata  in  32  data for the address presented the previous cycle
- IF_ID_Valid  out  1  IF/ID holds a live instruction
- IF_ID_PC  out  32  address of IF/ID instruction
- IF_ID_PC4  out  32  IF_ID_PC + 4
- IF_ID_Instr  out  32  instruction, NOP when invalid
- IF_ID_Opcode  out  8  {Instr[14:12], Instr[6:2]}
- IF_ID_Rs  out  5  Instr[19:15]
- IF_ID_Rt  out  5  Instr[24:20]
- IF_ID_Rd  out  5  Instr[11:7]
- stall_cnt  out  CNT_W  cycles with IF_ID_Hold = 0, saturating
- flush_cnt  out  CNT_W  cycles with IF_ID_Flush = 1, saturating
- protocol_err  out  1  sticky: PCWrite = 1 while IF_ID_Hold = 0 seen

## Operation
- State: pc_q, f2_pc_q, f2_valid_q, skid_q (32), use_skid_q, counters, protocol_err.
- PC update, priority order: rst -> RESET_PC; redirect_valid -> redirect_pc; PCWrite -> pc_q + 4 (mod 2^32); else hold.
- IF/ID update, priority order:
  - rst: f2_valid_q = 0, use_skid_q = 0.
  - IF_ID_Flush or redirect_valid: f2_valid_q = 0, use_skid_q = 0 (in-flight response discarded).
  - IF_ID_Hold = 0: f2_pc_q, f2_valid_q unchanged; if use_skid_q = 0, skid_q <= imem_rdata, use_skid_q <= 1; if already 1, skid unchanged.
  - else: f2_pc_q <= pc_q, f2_valid_q <= 1, use_skid_q <= 0.
- IF_ID_Instr = !f2_valid_q ? NOP : (use_skid_q ? skid_q : imem_rdata). Field outputs decode IF_ID_Instr, so an empty IF/ID never looks like a branch/jal/jalr.
- Flush beats hold; redirect beats PCWrite = 0.
- Counters: increment on the stated condition, stick at all-ones; rst clears.
- protocol_err set when PCWrite = 1 and IF_ID_Hold = 0 in the same cycle and neither flush nor redirect is active; cleared only by rst. Fetch behaviour in that case follows the rules above (sequential instruction is lost).

## Timing
- Reset values: pc_q = RESET_PC, imem_addr = RESET_PC, IF_ID_Valid = 0, IF_ID_Instr = NOP, IF_ID_PC = 0, counters 0, protocol_err 0.
- Cycle 0 after rst low: imem_addr = RESET_PC. Cycle 1: IF_ID_Valid = 1, IF_ID_PC = RESET_PC, IF_ID_Instr = mem[RESET_PC]; then one instruction per cycle.
- Memory latency exactly 1 cycle; fetch-to-IF/ID latency 1 cycle.
- Taken redirect in cycle n: cycle n+1 imem_addr = target, IF_ID_Valid = 0; cycle n+2 IF/ID = target (1-bubble penalty).
- Hold (PCWrite = 0, Hold = 0) for k cycles: IF/ID output stable all k cycles (first-cycle data captured into skid); cycle after release IF/ID = next sequential instruction, none lost or duplicated.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values next edge; skid discarded.
- Outputs are combinational from registers and imem_rdata only; no path from control inputs to outputs.

## Test plan
- Reset, RESET_PC = 0x100, mem[a] = a: cycles 1..4 IF_ID_PC = 0x100, 0x104, 0x108, 0x10C, Instr equal to PC, Valid = 1.
- Redirect to 0x200 while IF/ID = 0x108: next cycle Valid = 0, Instr = 0x00000013, Opcode = 0x04; then IF_ID_PC = 0x200; flush_cnt = 1.
- Load-use stall: PCWrite = 0, Hold = 0 for 3 cycles at IF/ID = 0x10C: Instr stays 0x10C, stall_cnt = 3; after release 0x110 then 0x114.
- Flush and Hold both asserted with redirect: flush wins, Valid = 0 next cycle, no skid reuse after target arrives.
- pc_q = 0xFFFFFFFC sequential: next imem_addr = 0x00000000; stall_cnt forced past 0xFFFF stays 0xFFFF.
- PCWrite = 1 with Hold = 0: protocol_err = 1 and stays 1 until rst; rst during a 2-cycle hold clears skid and restarts at RESET_PC.
